// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencer: PC, imem req/ack fetch, decoder valid/ready issue; return stack built only with `FETCH_STACK_EN.
// Latency: ack -> instr_valid next cycle, accept -> next imem_req next cycle; instruction holds while instr_ready is low.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH  = 10,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instruction,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic [2:0]            pcControl,
    input  logic [19:0]           target,
    input  logic                  cond,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  stack_err
);

    typedef enum logic [1:0] {
        S_RST,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [2:0] PC_JMP   = 3'd1;
    localparam logic [2:0] PC_JCOND = 3'd2;
    localparam logic [2:0] PC_HLT   = 3'd3;
`ifdef FETCH_STACK_EN
    localparam logic [2:0] PC_CALL  = 3'd4;
    localparam logic [2:0] PC_RET   = 3'd5;
`endif

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] tgt;
    logic                  accept;
    logic                  unused_target_bits;

    assign accept             = instr_valid && instr_ready;
    assign pc_inc             = pc + ADDR_WIDTH'(1);
    assign tgt                = target[ADDR_WIDTH-1:0];
    assign unused_target_bits = ^target[19:ADDR_WIDTH];

`ifdef FETCH_STACK_EN
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [ADDR_WIDTH-1:0] ret_stack [STACK_DEPTH];
    logic [SP_W-1:0]       sp;
    logic                  stack_full, stack_empty;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  do_push, do_pop, err_set;

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign stack_top   = ret_stack[IDX_W'(sp - SP_W'(1))];
`endif

    always_comb begin
        state_nxt = state;
        addr_nxt  = imem_addr;
`ifdef FETCH_STACK_EN
        do_push   = 1'b0;
        do_pop    = 1'b0;
        err_set   = 1'b0;
`endif
        case (state)
            S_RST:   state_nxt = S_FETCH;
            S_FETCH: if (imem_ack) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (accept) begin
                    state_nxt = S_FETCH;
                    addr_nxt  = pc_inc;
                    case (pcControl)
                        PC_JMP:   addr_nxt = tgt;
                        PC_JCOND: if (cond) addr_nxt = tgt;
                        PC_HLT:   state_nxt = S_HALT;
`ifdef FETCH_STACK_EN
                        // Stack misuse falls back to a sequential step and flags the error.
                        PC_CALL: begin
                            if (stack_full) begin
                                err_set = 1'b1;
                            end else begin
                                do_push  = 1'b1;
                                addr_nxt = tgt;
                            end
                        end
                        PC_RET: begin
                            if (stack_empty) begin
                                err_set = 1'b1;
                            end else begin
                                do_pop   = 1'b1;
                                addr_nxt = stack_top;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_RST;
            imem_req    <= 1'b0;
            imem_addr   <= PC_INIT;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= PC_INIT;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            imem_req    <= (state_nxt == S_FETCH);
            instr_valid <= (state_nxt == S_ISSUE);
            halted      <= (state_nxt == S_HALT);
            imem_addr   <= addr_nxt;
            if (state == S_FETCH && imem_ack) begin
                instruction <= imem_rdata;
                pc          <= imem_addr;
            end
        end
    end

`ifdef FETCH_STACK_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            if (do_push) sp <= sp + SP_W'(1);
            else if (do_pop) sp <= sp - SP_W'(1);
            if (err_set) stack_err <= 1'b1;
        end
    end

    // Storage needs no reset: the pointer alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) ret_stack[sp[IDX_W-1:0]] <= pc_inc;
    end
`else
    assign stack_err = 1'b0;
`endif

endmodule
